// File: rtl/ntt_stage_permutation_pipe.sv
// NTT stage lane permutation: out lane i takes in lane i with index bits 0
// and s swapped, behind a single-entry valid/ready register with frame tracking.
module ntt_stage_permutation_pipe #(
   parameter int DATA_WIDTH  = 32,
   parameter int LANES       = 32,
   parameter int FRAME_BEATS = 32,
   localparam int LOG_LANES = $clog2(LANES),
   localparam int SEL_W     = (LOG_LANES > 1) ? $clog2(LOG_LANES) : 1,
   localparam int CNT_W     = (FRAME_BEATS > 1) ? $clog2(FRAME_BEATS) : 1,
   localparam int BUS_W     = LANES * DATA_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [BUS_W-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SEL_W-1:0] stage_sel,
   output logic [BUS_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic             err_sel
);

   logic [DATA_WIDTH-1:0] lane_in [LANES];
   logic [BUS_W-1:0]      perm;
   logic                  sel_ok;

   logic [BUS_W-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             last_q, last_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic xfer_in;
   logic xfer_out;
   logic cnt_end;

   function automatic logic [LOG_LANES-1:0] src_idx(
      input logic [LOG_LANES-1:0] i,
      input logic [SEL_W-1:0]     s,
      input logic                 ok
   );
      logic [LOG_LANES-1:0] j;
      j = i;
      if (ok) begin
         j[0] = i[s];
         j[s] = i[0];
      end
      return j;
   endfunction

   assign sel_ok = 32'(stage_sel) < 32'(LOG_LANES);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      assign lane_in[g] = in_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign perm[g*DATA_WIDTH +: DATA_WIDTH] =
         lane_in[src_idx(LOG_LANES'(g), stage_sel, sel_ok)];
   end

   assign in_ready = !rst && (!valid_q || out_ready);
   assign xfer_in  = in_valid && in_ready;
   assign xfer_out = valid_q && out_ready;
   assign cnt_end  = (cnt_q == CNT_W'(FRAME_BEATS - 1));

   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      last_d  = last_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      if (xfer_in) begin
         data_d  = perm;
         valid_d = 1'b1;
         last_d  = cnt_end;
         err_d   = err_q || !sel_ok;
         cnt_d   = cnt_end ? '0 : cnt_q + CNT_W'(1);
      end else if (xfer_out) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_data  = data_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign err_sel   = err_q;

endmodule
